serial_sub: RTL

- Bit-serial unsigned subtractor: computes A − B one bit per clock, LSB first, with a start/busy/done handshake.
- Counterpart to the team's combinational adder cells (subtract instead of add, serial instead of parallel).
- Used by the game datapath for paddle/ball position deltas, where area matters more than latency.
- Built from two half-subtractor cells plus a registered borrow.

---
 rtl/serial_sub_pkg.sv | 23 ++
 rtl/serial_sub_half_sub.sv | 21 ++
 rtl/serial_sub.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/serial_sub_pkg.sv
// -----------------------------------------------------------------------------
// serial_sub_pkg
//   Shared types and constants for the bit-serial subtractor.
//   - state_t   : controller states (IDLE, SHIFT)
//   - MAX_WIDTH : largest supported operand width
//   - cnt_w()   : bit-counter width for a given operand width
// -----------------------------------------------------------------------------
package serial_sub_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int MAX_WIDTH = 32;

  // Counter only has to reach WIDTH-1; widths below 2 are rejected by the top,
  // the floor of 1 just keeps the vector legal.
  function automatic int cnt_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_sub_half_sub.sv
// -----------------------------------------------------------------------------
// half_sub
//   One-bit half subtractor, x - y.
//   Ports:
//     x  : minuend bit
//     y  : subtrahend bit
//     d  : difference bit  (x ^ y)
//     bo : borrow out      (~x & y)
//   Two of these plus an OR make a full-subtract bit.
// -----------------------------------------------------------------------------
module half_sub (
  input  logic x,
  input  logic y,
  output logic d,
  output logic bo
);

  assign d  = x ^ y;
  assign bo = ~x & y;

endmodule

// File: rtl/serial_sub.sv
// -----------------------------------------------------------------------------
// serial_sub
//   Bit-serial unsigned subtractor: diff = a - b mod 2^WIDTH, one bit per clock,
//   LSB first, with a start/busy/done handshake. Result appears WIDTH cycles
//   after the accepting edge and is held until the next accepted start.
//
//   Parameters:
//     WIDTH  : operand/result width, 2..MAX_WIDTH
//
//   Ports:
//     clk    : clock, rising edge
//     rst_n  : asynchronous active-low reset
//     strt   : start request, only looked at in IDLE
//     a, b   : minuend / subtrahend, captured on the accepting edge
//     diff   : result, valid from done onward
//     borrow : final borrow (a < b), valid like diff
//     busy   : high while bits are being shifted
//     done   : one-cycle pulse when the result becomes valid
//
//   Build option:
//     SERIAL_SUB_SAT_EN : saturating mode; a result with final borrow reads as
//                         zero on diff (borrow still reported). Timing is the
//                         same in both builds.
// -----------------------------------------------------------------------------
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             strt,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             busy,
  output logic             done
);

  localparam int             CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("serial_sub: WIDTH %0d outside 2..%0d", WIDTH, MAX_WIDTH);
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_shft, b_shft, diff_shft;
  logic [CW-1:0]    cnt;
  logic             bin;      // running borrow; doubles as the borrow output
  logic             done_q;

  // FSM decode
  logic             load, step, fin, last;

  // Full-subtract bit
  logic             abit, bbit, d1, bo1, dbit, bo2, bout;

  assign last = (cnt == LAST);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (strt) state_nxt = SHIFT;
      SHIFT:   if (last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs / datapath controls
  //   load : accept operands (IDLE with strt)
  //   step : process one bit
  //   fin  : this step is the final bit; done fires next cycle
  // ---------------------------------------------------------------------------
  always_comb begin
    load = 1'b0;
    step = 1'b0;
    fin  = 1'b0;
    case (state)
      IDLE:  load = strt;
      SHIFT: begin
        step = 1'b1;
        fin  = last;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Full-subtract bit from two half subtractors:
  //   first stage a - b, second stage subtracts the incoming borrow.
  //   At most one stage can borrow, so OR is the full borrow.
  // ---------------------------------------------------------------------------
  assign abit = a_shft[0];
  assign bbit = b_shft[0];

  half_sub u_hs0 (
    .x  (abit),
    .y  (bbit),
    .d  (d1),
    .bo (bo1)
  );

  half_sub u_hs1 (
    .x  (d1),
    .y  (bin),
    .d  (dbit),
    .bo (bo2)
  );

  assign bout = bo1 | bo2;

  // ---------------------------------------------------------------------------
  // Datapath registers
  //   diff_shft fills from the MSB so that after WIDTH steps bit 0 of the
  //   result has walked down to bit 0.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_shft    <= '0;
      b_shft    <= '0;
      diff_shft <= '0;
      bin       <= 1'b0;
      cnt       <= '0;
    end else if (load) begin
      a_shft    <= a;
      b_shft    <= b;
      diff_shft <= '0;
      bin       <= 1'b0;
      cnt       <= '0;
    end else if (step) begin
      a_shft    <= a_shft >> 1;
      b_shft    <= b_shft >> 1;
      diff_shft <= {dbit, diff_shft[WIDTH-1:1]};
      bin       <= bout;
      cnt       <= cnt + CW'(1);
    end
  end

  // done is a pure one-cycle echo of the final step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done_q <= 1'b0;
    else        done_q <= fin;
  end

  // ---------------------------------------------------------------------------
  // Outputs (all derived from flops only)
  // ---------------------------------------------------------------------------
  assign busy   = (state == SHIFT);
  assign done   = done_q;
  assign borrow = bin;

`ifdef SERIAL_SUB_SAT_EN
  // Only mask once back in IDLE: mid-shift the running borrow is not final.
  assign diff = (bin && state == IDLE) ? '0 : diff_shft;
`else
  assign diff = diff_shft;
`endif

endmodule
